instr_stat_counter: RTL

Parametrised instruction-mix profiler for the single-cycle MIPS core. It sits beside the datapath, decodes each retiring instruction's opcode into one of six classes and keeps eight event counters: cycles, retired, and one per class. Counters are CNT_W bits wide with selectable saturate/wrap behaviour and sticky overflow flags. An atomic snapshot bank and a registered read port let software or the testbench sample all counters coherently.

---
 rtl/instr_stat_counter_if.sv | 24 ++
 rtl/instr_stat_counter.sv | 111 +++++++++++
 2 files changed

// File: rtl/instr_stat_counter_if.sv
// Control and readout bundle for the instruction-mix profiler.
// The profiler owns the slave side; the core or the bench drives the master side.
interface instr_stat_counter_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             instr_valid;
  logic [5:0]       op;
  logic             clear;
  logic             snap;
  logic [2:0]       rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic [7:0]       ovf;

  modport master (
    output en, instr_valid, op, clear, snap, rd_sel,
    input  rd_data, ovf
  );

  modport slave (
    input  en, instr_valid, op, clear, snap, rd_sel,
    output rd_data, ovf
  );
endinterface

// File: rtl/instr_stat_counter.sv
// Instruction-mix profiler: eight live counters (cycles, retired, six opcode classes),
// saturate/wrap overflow with sticky flags, atomic snapshot bank and registered read port.
module instr_stat_counter #(
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_stat_counter_if.slave  bus
);

  localparam int N_CNT = 8;

  typedef enum logic [2:0] {
    CNT_CYCLES  = 3'd0,
    CNT_RETIRED = 3'd1,
    CNT_RTYPE   = 3'd2,
    CNT_IALU    = 3'd3,
    CNT_LOAD    = 3'd4,
    CNT_STORE   = 3'd5,
    CNT_BRANCH  = 3'd6,
    CNT_JUMP    = 3'd7
  } cnt_idx_e;

  logic [N_CNT-1:0][CNT_W-1:0] r_cnt;
  logic [N_CNT-1:0][CNT_W-1:0] r_shadow;
  logic [N_CNT-1:0]            r_ovf;
  logic [CNT_W-1:0]            r_rd_data;

  logic [5:0]                  w_cls;
  logic [N_CNT-1:0]            w_inc;
  logic [N_CNT-1:0]            w_carry;
  logic [N_CNT-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [N_CNT-1:0]            w_ovf_nxt;

  // One-hot class decode; bit k of w_cls maps to counter index k+2.
  always_comb begin
    w_cls = 6'b000000;
    casez (bus.op)
      6'b000000:                                  w_cls[CNT_RTYPE  - 2] = 1'b1;
      6'b001???:                                  w_cls[CNT_IALU   - 2] = 1'b1;
      6'b100000, 6'b100001, 6'b100011,
      6'b100100, 6'b100101:                       w_cls[CNT_LOAD   - 2] = 1'b1;
      6'b101000, 6'b101001, 6'b101011:            w_cls[CNT_STORE  - 2] = 1'b1;
      6'b000001, 6'b0001??:                       w_cls[CNT_BRANCH - 2] = 1'b1;
      6'b00001?:                                  w_cls[CNT_JUMP   - 2] = 1'b1;
      default:                                    w_cls = 6'b000000;
    endcase
  end

  always_comb begin
    w_inc              = '0;
    w_inc[CNT_CYCLES]  = bus.en;
    w_inc[CNT_RETIRED] = bus.en & bus.instr_valid;
    w_inc[N_CNT-1:2]   = w_cls & {6{bus.en & bus.instr_valid}};
  end

  // The adder carry-out flags the all-ones increment; it never lands in the counter.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    w_carry   = '0;
    for (int i = 0; i < N_CNT; i++) begin
      logic [CNT_W:0] w_sum;
      w_sum      = {1'b0, r_cnt[i]} + {{CNT_W{1'b0}}, 1'b1};
      w_carry[i] = w_sum[CNT_W];
      if (bus.clear) begin
        w_cnt_nxt[i] = '0;
        w_ovf_nxt[i] = 1'b0;
      end else if (w_inc[i]) begin
        if (w_carry[i]) begin
          w_ovf_nxt[i] = 1'b1;
          w_cnt_nxt[i] = SATURATE ? r_cnt[i] : '0;
        end else begin
          w_cnt_nxt[i] = w_sum[CNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  // Shadow captures pre-edge live values, so snap together with clear is a read-and-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (bus.snap) begin
      r_shadow <= r_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_shadow[bus.rd_sel];
    end
  end

  assign bus.rd_data = r_rd_data;
  assign bus.ovf     = r_ovf;

endmodule
